// File: rtl/ccm_port_arb.sv
// rtl/ccm_port_arb.sv - fetch/load/store arbiter for a shared single-port CCM SRAM
// Optional perf counters: define CCM_ARB_PERF_EN.
module ccm_port_arb #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_rd_req,
  input  logic [31:0]       ls_rd_addr,
  input  logic              ls_wr_req,
  input  logic [31:0]       ls_wr_addr,
  input  logic [31:0]       ls_wr_data,
  output logic              ls_rd_gnt,
  output logic              ls_wr_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
`ifdef CCM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflict_cnt,
  output logic [31:0]       perf_starve_cnt
`endif
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IFU  = 2'd1;
  localparam logic [1:0] OWN_LSU  = 2'd2;
  localparam logic [7:0] MAX_W    = 8'(MAX_WAIT);

  logic [1:0] rd_owner;
  logic [7:0] wait_cnt;
  logic       starve;

  assign starve = (MAX_WAIT != 0) && (wait_cnt == MAX_W);

  // Grants are held low while reset is asserted so every output sits at its reset value.
  always_comb begin
    if_gnt    = 1'b0;
    ls_wr_gnt = 1'b0;
    ls_rd_gnt = 1'b0;
    if (rst_n) begin
      if (starve && if_req)  if_gnt    = 1'b1;
      else if (ls_wr_req)    ls_wr_gnt = 1'b1;
      else if (ls_rd_req)    ls_rd_gnt = 1'b1;
      else if (if_req)       if_gnt    = 1'b1;
    end
  end

  always_comb begin
    sram_en    = if_gnt | ls_wr_gnt | ls_rd_gnt;
    sram_we    = ls_wr_gnt;
    sram_addr  = '0;
    sram_wdata = '0;
    if (ls_wr_gnt) begin
      sram_addr  = ls_wr_addr[ADDR_W+1:2];
      sram_wdata = ls_wr_data;
    end else if (ls_rd_gnt) begin
      sram_addr  = ls_rd_addr[ADDR_W+1:2];
    end else if (if_gnt) begin
      sram_addr  = if_addr[ADDR_W+1:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner <= OWN_NONE;
    end else if (if_gnt) begin
      rd_owner <= OWN_IFU;
    end else if (ls_rd_gnt) begin
      rd_owner <= OWN_LSU;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (if_gnt || !if_req) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != MAX_W) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign if_rvalid = (rd_owner == OWN_IFU) && !if_kill;
  assign ls_rvalid = (rd_owner == OWN_LSU);
  assign if_rdata  = sram_rdata;
  assign ls_rdata  = sram_rdata;

`ifdef CCM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_cnt <= 32'd0;
      perf_starve_cnt   <= 32'd0;
    end else begin
      if (if_req && !if_gnt) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (if_gnt && starve)  perf_starve_cnt   <= perf_starve_cnt + 32'd1;
    end
  end
`endif

  // Only the word-address bits reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              ls_rd_addr[31:ADDR_W+2], ls_rd_addr[1:0],
                              ls_wr_addr[31:ADDR_W+2], ls_wr_addr[1:0]};

endmodule

// File: tb/tb_ccm_port_arb.sv
// tb/tb_ccm_port_arb.sv - randomized and directed bench for ccm_port_arb
// Perf counter checks are active when CCM_ARB_PERF_EN is defined.
module tb_ccm_port_arb;
  localparam int ADDR_W   = 14;
  localparam int MAX_WAIT = 4;
  localparam int W_NONE = 0, W_IF = 1, W_WR = 2, W_RD = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_kill, ls_rd_req, ls_wr_req;
  logic [31:0]       if_addr, ls_rd_addr, ls_wr_addr, ls_wr_data;
  logic              if_gnt, if_rvalid, ls_rd_gnt, ls_wr_gnt, ls_rvalid;
  logic [31:0]       if_rdata, ls_rdata, sram_wdata;
  logic              sram_en, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_rdata;
`ifdef CCM_ARB_PERF_EN
  logic [31:0]       perf_conflict_cnt, perf_starve_cnt;
`endif

  ccm_port_arb #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_rd_req(ls_rd_req), .ls_rd_addr(ls_rd_addr),
    .ls_wr_req(ls_wr_req), .ls_wr_addr(ls_wr_addr), .ls_wr_data(ls_wr_data),
    .ls_rd_gnt(ls_rd_gnt), .ls_wr_gnt(ls_wr_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef CCM_ARB_PERF_EN
    , .perf_conflict_cnt(perf_conflict_cnt), .perf_starve_cnt(perf_starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM macro behaviour seen by the arbiter
  logic [31:0] sram_mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: word-addressed memory plus who won, who waits, what is due
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  int          m_wait, m_win;
  bit          m_if_due, m_ls_due, m_if_req_c, m_starve_c;
  logic [31:0] m_if_data, m_ls_data, m_wdata_c;
  int          m_idx;
  int unsigned m_conf, m_stv;

  function automatic int word_of(input logic [31:0] a);
    return int'(a / 4) % (1 << ADDR_W);
  endfunction

  task automatic model_reset();
    m_wait = 0; m_win = W_NONE; m_if_due = 0; m_ls_due = 0;
    m_conf = 0; m_stv = 0;
  endtask

  task automatic model_check();
    logic [31:0] a;
    m_starve_c = (MAX_WAIT != 0) && (m_wait == MAX_WAIT);
    if (m_starve_c && if_req) m_win = W_IF;
    else if (ls_wr_req)       m_win = W_WR;
    else if (ls_rd_req)       m_win = W_RD;
    else if (if_req)          m_win = W_IF;
    else                      m_win = W_NONE;
    a = (m_win == W_WR) ? ls_wr_addr : (m_win == W_RD) ? ls_rd_addr :
        (m_win == W_IF) ? if_addr : 32'd0;
    m_idx = word_of(a);
    m_if_req_c = if_req;
    m_wdata_c  = ls_wr_data;
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, m_win == W_IF});
    chk("ls_wr_gnt", {31'd0, ls_wr_gnt}, {31'd0, m_win == W_WR});
    chk("ls_rd_gnt", {31'd0, ls_rd_gnt}, {31'd0, m_win == W_RD});
    chk("sram_en", {31'd0, sram_en}, {31'd0, m_win != W_NONE});
    chk("sram_we", {31'd0, sram_we}, {31'd0, m_win == W_WR});
    chk("sram_addr", {18'd0, sram_addr}, m_idx);
    chk("sram_wdata", sram_wdata, (m_win == W_WR) ? ls_wr_data : 32'd0);
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_if_due && !if_kill});
    if (m_if_due && !if_kill) chk("if_rdata", if_rdata, m_if_data);
    chk("ls_rvalid", {31'd0, ls_rvalid}, {31'd0, m_ls_due});
    if (m_ls_due) chk("ls_rdata", ls_rdata, m_ls_data);
`ifdef CCM_ARB_PERF_EN
    chk("perf_conflict", perf_conflict_cnt, m_conf);
    chk("perf_starve", perf_starve_cnt, m_stv);
`endif
  endtask

  task automatic model_update();
    m_if_due = (m_win == W_IF);
    m_ls_due = (m_win == W_RD);
    if (m_win == W_IF) m_if_data = ref_mem[m_idx];
    if (m_win == W_RD) m_ls_data = ref_mem[m_idx];
    if (m_win == W_WR) ref_mem[m_idx] = m_wdata_c;
    if (m_if_req_c && m_win != W_IF) m_conf++;
    if (m_win == W_IF && m_starve_c) m_stv++;
    if (m_win == W_IF || !m_if_req_c) m_wait = 0;
    else if (m_wait < MAX_WAIT)       m_wait++;
  endtask

  // Inputs are set by the caller before tick; returns at posedge+1.
  task automatic tick();
    @(negedge clk); #1;
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    logic [31:0] w;
    r = $urandom();
    w = $urandom_range(0, 31);
    return {r[31:16], 9'd0, w[4:0], r[1:0]};
  endfunction

  task automatic idle_inputs();
    if_req = 0; if_kill = 0; ls_rd_req = 0; ls_wr_req = 0;
    if_addr = 0; ls_rd_addr = 0; ls_wr_addr = 0; ls_wr_data = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      sram_mem[i] = 32'd0;
      ref_mem[i]  = 32'd0;
    end
    sram_rdata = 32'd0;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    chk("rst_sram_en", {31'd0, sram_en}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // store then load at byte 0x40
    ls_wr_req = 1; ls_wr_addr = 32'h40; ls_wr_data = 32'hDEADBEEF;
    #1 chk("t1_wr_addr", {18'd0, sram_addr}, 32'h10);
    tick();
    ls_wr_req = 0; ls_rd_req = 1; ls_rd_addr = 32'h40;
    #1 chk("t1_rd_addr", {18'd0, sram_addr}, 32'h10);
    tick();
    ls_rd_req = 0;
    #1 chk("t1_rvalid", {31'd0, ls_rvalid}, 32'd1);
    chk("t1_rdata", ls_rdata, 32'hDEADBEEF);
    tick();

    // three simultaneous requests
    if_req = 1; if_addr = 32'h100; ls_wr_req = 1; ls_wr_addr = 32'h80; ls_wr_data = 32'h1234_5678;
    ls_rd_req = 1; ls_rd_addr = 32'h80;
    #1 chk("t2_c1_wr", {31'd0, ls_wr_gnt}, 32'd1);
    tick();
    ls_wr_req = 0;
    #1 chk("t2_c2_rd", {31'd0, ls_rd_gnt}, 32'd1);
    tick();
    ls_rd_req = 0;
    #1 chk("t2_c3_if", {31'd0, if_gnt}, 32'd1);
    chk("t2_c3_ldata", ls_rdata, 32'h1234_5678);
    tick();
    if_req = 0;
    #1 chk("t2_c4_ifv", {31'd0, if_rvalid}, 32'd1);
    tick();

    // starvation guard with a continuous load stream
    if_req = 1; if_addr = 32'h200; ls_rd_req = 1;
    for (int i = 0; i < 5; i++) begin
      ls_rd_addr = 32'(i * 4);
      #1 chk("t3_if_gnt", {31'd0, if_gnt}, {31'd0, i == 4});
      chk("t3_rd_gnt", {31'd0, ls_rd_gnt}, {31'd0, i != 4});
      tick();
    end
    if_req = 0; ls_rd_req = 0;
    tick();
    tick();

    // flush of an outstanding fetch
    if_req = 1; if_addr = 32'h100;
    tick();
    if_kill = 1; if_addr = 32'h104;
    #1 chk("t4_killed", {31'd0, if_rvalid}, 32'd0);
    chk("t4_regrant", {31'd0, if_gnt}, 32'd1);
    tick();
    if_kill = 0; if_req = 0;
    #1 chk("t4_second", {31'd0, if_rvalid}, 32'd1);
    tick();

    // reset while a load is in flight
    ls_rd_req = 1; ls_rd_addr = 32'h40;
    #1 chk("t5_gnt", {31'd0, ls_rd_gnt}, 32'd1);
    rst_n = 0;
    #1 chk("t5_rst_gnt", {31'd0, ls_rd_gnt}, 32'd0);
    chk("t5_rst_en", {31'd0, sram_en}, 32'd0);
    ls_rd_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk("t5_rst_rvalid", {31'd0, ls_rvalid}, 32'd0);
    @(negedge clk) rst_n = 1;
    tick();
    chk("t5_post_rvalid", {31'd0, ls_rvalid}, 32'd0);

`ifdef CCM_ARB_PERF_EN
    if_req = 1; if_addr = 32'h300; ls_rd_req = 1;
    for (int i = 0; i < 10; i++) begin
      ls_rd_addr = 32'(i * 4);
      tick();
    end
    idle_inputs();
    chk("t6_conflict", perf_conflict_cnt, 32'd8);
    chk("t6_starve", perf_starve_cnt, 32'd2);
    tick();
`endif

    // randomized traffic; requesters hold until granted
    idle_inputs();
    m_win = W_NONE;
    repeat (3000) begin
      if (!if_req || m_win == W_IF) begin
        if_req = ($urandom_range(0, 2) != 0); if_addr = rand_addr();
      end
      if (!ls_wr_req || m_win == W_WR) begin
        ls_wr_req = ($urandom_range(0, 2) == 0); ls_wr_addr = rand_addr(); ls_wr_data = $urandom();
      end
      if (!ls_rd_req || m_win == W_RD) begin
        ls_rd_req = ($urandom_range(0, 1) == 0); ls_rd_addr = rand_addr();
      end
      if_kill = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
